// File: rtl/audio_pkg.sv
// Shared types and helpers for the clap detector.
//   state_t   : detector FSM encoding (IDLE=0, ARM=1, HOLD=2, REFRACT=3)
//   STATE_W   : width of the encoded state
//   cnt_width : bits needed to hold values 0..n-1 (minimum 1)
package audio_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      HOLD    = 2'd2,
      REFRACT = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sample_magnitude.sv
// Combinational absolute value of one signed sample.
//   sample : signed DATA_WIDTH-bit PCM sample
//   mag    : unsigned DATA_WIDTH-1 magnitude; the most-negative input
//            saturates to all ones instead of wrapping to zero
module sample_magnitude #(
   parameter int DATA_WIDTH = 32
) (
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic        [DATA_WIDTH-2:0] mag
);

   localparam logic [DATA_WIDTH-2:0] ONE = (DATA_WIDTH-1)'(1);

   // For negative x the true magnitude fits in DATA_WIDTH-1 bits (except the
   // most-negative value), so negating only the low bits gives the same result.
   always_comb begin
      if (!sample[DATA_WIDTH-1]) begin
         mag = sample[DATA_WIDTH-2:0];
      end else if (sample[DATA_WIDTH-2:0] == '0) begin
         mag = '1;
      end else begin
         mag = ~sample[DATA_WIDTH-2:0] + ONE;
      end
   end

endmodule

// File: rtl/audio_clap_detector.sv
// Multi-channel transient (clap) detector.
//   CLOCK_50      : system clock
//   reset         : synchronous active-high reset
//   enable        : detection enable; low forces the FSM to IDLE
//   all_mode      : 0 = any channel qualifies a frame, 1 = all channels must
//   sample_valid  : one frame on sample_data this cycle
//   sample_data   : NUM_CH packed signed samples, channel 0 in the LSBs
//   threshold     : unsigned magnitude threshold (strict greater-than)
//   clap_pulse    : one-cycle strobe on entry to HOLD
//   clap_detected : high for the hold window
//   channel_hit   : per-channel mag > threshold of the last frame
//   peak_mag      : largest magnitude since the last clap_pulse
//   clap_count    : wrapping clap counter
//   state         : FSM state for debug
//
// state   | meaning
// IDLE    | waiting for a qualifying frame
// ARM     | counting consecutive qualifying frames
// HOLD    | clap declared, clap_detected high, hits ignored
// REFRACT | lockout after hold, hits ignored
module audio_clap_detector
   import audio_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int NUM_CH          = 2,
   parameter int MIN_HITS        = 3,
   parameter int HOLD_SAMPLES    = 4800,
   parameter int REFRACT_SAMPLES = 12000,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         all_mode,
   input  logic                         sample_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] sample_data,
   input  logic [DATA_WIDTH-2:0]        threshold,
   output logic                         clap_pulse,
   output logic                         clap_detected,
   output logic [NUM_CH-1:0]            channel_hit,
   output logic [DATA_WIDTH-2:0]        peak_mag,
   output logic [COUNT_WIDTH-1:0]       clap_count,
   output logic [STATE_W-1:0]           state
);

   localparam int MAG_W  = DATA_WIDTH - 1;
   localparam int RUN_W  = cnt_width(MIN_HITS);
   localparam int HOLD_W = cnt_width(HOLD_SAMPLES);
   localparam int REF_W  = cnt_width(REFRACT_SAMPLES);

   localparam logic [RUN_W-1:0]       RUN_ONE   = RUN_W'(1);
   localparam logic [RUN_W-1:0]       RUN_LAST  = RUN_W'((MIN_HITS > 1) ? MIN_HITS - 1 : 0);
   localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_SAMPLES - 1);
   localparam logic [REF_W-1:0]       REF_ONE   = REF_W'(1);
   localparam logic [REF_W-1:0]       REF_LOAD  = REF_W'((REFRACT_SAMPLES > 0) ? REFRACT_SAMPLES - 1 : 0);
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   logic [MAG_W-1:0]  mag [NUM_CH];
   logic [NUM_CH-1:0] hit_now;
   logic [MAG_W-1:0]  max_now;
   logic              frame_hit_now;

   logic              v1;
   logic              frame_hit;
   logic [MAG_W-1:0]  frame_max;

   state_t            cur_state, nxt_state;
   logic [RUN_W-1:0]  hit_run, hit_run_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [REF_W-1:0]  ref_cnt, ref_nxt;
   logic              det_nxt, pulse_nxt, enter_hold;
   logic [COUNT_WIDTH-1:0] count_nxt;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sample_magnitude #(.DATA_WIDTH(DATA_WIDTH)) u_mag (
         .sample (sample_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .mag    (mag[c])
      );
   end

   always_comb begin
      hit_now = '0;
      max_now = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         hit_now[c] = mag[c] > threshold;
         if (mag[c] > max_now) max_now = mag[c];
      end
      frame_hit_now = all_mode ? (&hit_now) : (|hit_now);
   end

   // Stage 1: registered per-frame decisions; held between frames.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         v1          <= 1'b0;
         channel_hit <= '0;
         frame_hit   <= 1'b0;
         frame_max   <= '0;
      end else begin
         v1 <= sample_valid;
         if (sample_valid) begin
            channel_hit <= hit_now;
            frame_hit   <= frame_hit_now;
            frame_max   <= max_now;
         end
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      hit_run_nxt = hit_run;
      hold_nxt    = hold_cnt;
      ref_nxt     = ref_cnt;
      det_nxt     = clap_detected;
      pulse_nxt   = 1'b0;
      count_nxt   = clap_count;
      enter_hold  = 1'b0;
      if (!enable) begin
         nxt_state   = IDLE;
         hit_run_nxt = '0;
         hold_nxt    = '0;
         ref_nxt     = '0;
         det_nxt     = 1'b0;
      end else if (v1) begin
         case (cur_state)
            IDLE: begin
               if (frame_hit) begin
                  if (MIN_HITS == 1) begin
                     enter_hold = 1'b1;
                  end else begin
                     hit_run_nxt = RUN_ONE;
                     nxt_state   = ARM;
                  end
               end
            end
            ARM: begin
               if (frame_hit) begin
                  if (hit_run == RUN_LAST) enter_hold = 1'b1;
                  else hit_run_nxt = hit_run + RUN_ONE;
               end else begin
                  hit_run_nxt = '0;
                  nxt_state   = IDLE;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  det_nxt = 1'b0;
                  if (REFRACT_SAMPLES == 0) begin
                     nxt_state = IDLE;
                  end else begin
                     nxt_state = REFRACT;
                     ref_nxt   = REF_LOAD;
                  end
               end else begin
                  hold_nxt = hold_cnt - HOLD_ONE;
               end
            end
            REFRACT: begin
               if (ref_cnt == '0) nxt_state = IDLE;
               else ref_nxt = ref_cnt - REF_ONE;
            end
            default: nxt_state = IDLE;
         endcase
         if (enter_hold) begin
            nxt_state   = HOLD;
            hit_run_nxt = '0;
            hold_nxt    = HOLD_LOAD;
            det_nxt     = 1'b1;
            pulse_nxt   = 1'b1;
            count_nxt   = clap_count + COUNT_ONE;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cur_state     <= IDLE;
         hit_run       <= '0;
         hold_cnt      <= '0;
         ref_cnt       <= '0;
         clap_pulse    <= 1'b0;
         clap_detected <= 1'b0;
         clap_count    <= '0;
         peak_mag      <= '0;
      end else begin
         cur_state     <= nxt_state;
         hit_run       <= hit_run_nxt;
         hold_cnt      <= hold_nxt;
         ref_cnt       <= ref_nxt;
         clap_pulse    <= pulse_nxt;
         clap_detected <= det_nxt;
         clap_count    <= count_nxt;
         // The pulse frame restarts peak tracking with its own maximum.
         if (v1) begin
            if (pulse_nxt || (frame_max > peak_mag)) peak_mag <= frame_max;
         end
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_audio_clap_detector.sv
module tb_audio_clap_detector;

   localparam int DW    = 16;
   localparam int NCH   = 2;
   localparam int MINH  = 3;
   localparam int HOLDN = 4;
   localparam int REFN  = 8;

   logic              CLOCK_50 = 1'b0;
   logic              reset = 1'b0;
   logic              enable = 1'b1;
   logic              all_mode = 1'b0;
   logic              sample_valid = 1'b0;
   logic [NCH*DW-1:0] sample_data = '0;
   logic [DW-2:0]     threshold = 15'h1000;
   logic              clap_pulse;
   logic              clap_detected;
   logic [NCH-1:0]    channel_hit;
   logic [DW-2:0]     peak_mag;
   logic [15:0]       clap_count;
   logic [1:0]        state;

   audio_clap_detector #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .MIN_HITS(MINH),
      .HOLD_SAMPLES(HOLDN), .REFRACT_SAMPLES(REFN), .COUNT_WIDTH(16)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .all_mode(all_mode),
      .sample_valid(sample_valid), .sample_data(sample_data), .threshold(threshold),
      .clap_pulse(clap_pulse), .clap_detected(clap_detected), .channel_hit(channel_hit),
      .peak_mag(peak_mag), .clap_count(clap_count), .state(state)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic        pulse;
      logic        det;
      logic [15:0] count;
      logic [14:0] peak;
      logic [1:0]  st;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int pulse_total = 0;
   int det_total = 0;
   int ref_total = 0;
   int frame_no = 0;
   int last_pulse_frame = 0;
   logic [1:0] pipe = 2'b00;

   // frame-level reference model
   int          m_st = 0, m_run = 0, m_hold = 0, m_ref = 0;
   logic        m_det = 1'b0;
   logic [15:0] m_count = '0;
   logic [14:0] m_peak = '0;

   function automatic logic [14:0] mag_of(input logic [15:0] x);
      logic [15:0] n;
      if (x == 16'h8000) return 15'h7FFF;
      if (x[15]) begin
         n = ~x + 16'd1;
         return n[14:0];
      end
      return x[14:0];
   endfunction

   task automatic model_clear();
      m_st = 0; m_run = 0; m_hold = 0; m_ref = 0; m_det = 1'b0;
   endtask

   task automatic model_frame(input logic [15:0] c0, input logic [15:0] c1);
      logic [14:0] a0, a1, fmax;
      logic        fh;
      exp_t        e;
      a0   = mag_of(c0);
      a1   = mag_of(c1);
      fh   = all_mode ? ((a0 > threshold) && (a1 > threshold))
                      : ((a0 > threshold) || (a1 > threshold));
      fmax = (a0 > a1) ? a0 : a1;
      e.pulse = 1'b0;
      if (enable) begin
         case (m_st)
            0: if (fh) begin m_run = 1; m_st = 1; end
            1: begin
               if (fh) begin
                  m_run++;
                  if (m_run == MINH) begin
                     m_st = 2; m_run = 0; m_hold = HOLDN - 1; m_det = 1'b1;
                     m_count = m_count + 16'd1; e.pulse = 1'b1;
                  end
               end else begin
                  m_run = 0; m_st = 0;
               end
            end
            2: begin
               if (m_hold == 0) begin m_det = 1'b0; m_st = 3; m_ref = REFN - 1; end
               else m_hold--;
            end
            default: begin
               if (m_ref == 0) m_st = 0;
               else m_ref--;
            end
         endcase
      end
      m_peak  = (e.pulse || fmax > m_peak) ? fmax : m_peak;
      e.det   = m_det;
      e.count = m_count;
      e.peak  = m_peak;
      e.st    = 2'(m_st);
      exp_q.push_back(e);
   endtask

   // One clock: sample outputs at the falling edge, retire scoreboard entries
   // two edges after the frame was presented.
   task automatic tick();
      exp_t e;
      @(posedge CLOCK_50);
      pipe = {pipe[0], sample_valid};
      @(negedge CLOCK_50);
      if (clap_pulse) begin
         pulse_total++;
         last_pulse_frame = frame_no + 1;
      end
      if (clap_detected) det_total++;
      if (state == 2'd3) ref_total++;
      if (pipe[1]) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow: output frame with no expectation at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            frame_no++;
            checks++;
            if (clap_pulse !== e.pulse) begin
               failures++;
               $display("FAIL sb_pulse frame=%0d got=%b exp=%b", frame_no, clap_pulse, e.pulse);
            end
            checks++;
            if (clap_detected !== e.det) begin
               failures++;
               $display("FAIL sb_detected frame=%0d got=%b exp=%b", frame_no, clap_detected, e.det);
            end
            checks++;
            if (clap_count !== e.count) begin
               failures++;
               $display("FAIL sb_count frame=%0d got=%0d exp=%0d", frame_no, clap_count, e.count);
            end
            checks++;
            if (peak_mag !== e.peak) begin
               failures++;
               $display("FAIL sb_peak frame=%0d got=%h exp=%h", frame_no, peak_mag, e.peak);
            end
            checks++;
            if (state !== e.st) begin
               failures++;
               $display("FAIL sb_state frame=%0d got=%0d exp=%0d", frame_no, state, e.st);
            end
         end
      end
   endtask

   task automatic drive_frame(input logic [15:0] c0, input logic [15:0] c1);
      sample_valid = 1'b1;
      sample_data  = {c1, c0};
      model_frame(c0, c1);
      tick();
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      sample_valid = 1'b0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      model_clear();
      m_count = '0;
      m_peak  = '0;
      exp_q.delete();
      pipe = 2'b00;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (clap_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", clap_pulse); end
      checks++; if (clap_detected !== 1'b0) begin failures++; $display("FAIL reset_detected got=%b exp=0", clap_detected); end
      checks++; if (clap_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", clap_count); end
      checks++; if (peak_mag !== 15'd0) begin failures++; $display("FAIL reset_peak got=%h exp=0", peak_mag); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (channel_hit !== 2'b00) begin failures++; $display("FAIL reset_channel_hit got=%b exp=00", channel_hit); end
   endtask

   task automatic test_single_clap();
      int p0, d0, r0, f0;
      p0 = pulse_total; d0 = det_total; r0 = ref_total; f0 = frame_no;
      repeat (3) drive_frame(16'h2000, 16'h0000);
      repeat (12) drive_frame(16'h0000, 16'h0000);
      idle(2);
      checks++; if (pulse_total - p0 !== 1) begin failures++; $display("FAIL single_pulse_count got=%0d exp=1", pulse_total - p0); end
      checks++; if (last_pulse_frame - f0 !== 3) begin failures++; $display("FAIL single_pulse_frame got=%0d exp=3", last_pulse_frame - f0); end
      checks++; if (clap_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", clap_count); end
      checks++; if (det_total - d0 !== HOLDN) begin failures++; $display("FAIL single_hold_len got=%0d exp=%0d", det_total - d0, HOLDN); end
      checks++; if (ref_total - r0 !== REFN) begin failures++; $display("FAIL single_refract_len got=%0d exp=%0d", ref_total - r0, REFN); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL single_end_state got=%0d exp=0", state); end
   endtask

   task automatic test_debounce();
      int p0, f0;
      p0 = pulse_total; f0 = frame_no;
      drive_frame(16'h2000, 16'h0000);
      drive_frame(16'h2000, 16'h0000);
      drive_frame(16'h0000, 16'h0000);
      drive_frame(16'h2000, 16'h0000);
      drive_frame(16'h2000, 16'h0000);
      drive_frame(16'h2000, 16'h0000);
      repeat (12) drive_frame(16'h0000, 16'h0000);
      idle(2);
      checks++; if (pulse_total - p0 !== 1) begin failures++; $display("FAIL debounce_pulse_count got=%0d exp=1", pulse_total - p0); end
      checks++; if (last_pulse_frame - f0 !== 6) begin failures++; $display("FAIL debounce_pulse_frame got=%0d exp=6", last_pulse_frame - f0); end
      drive_frame(16'h1000, 16'h0000);
      checks++; if (channel_hit !== 2'b00) begin failures++; $display("FAIL equal_threshold_hit got=%b exp=00", channel_hit); end
      drive_frame(16'h0000, 16'h1001);
      checks++; if (channel_hit !== 2'b10) begin failures++; $display("FAIL above_threshold_ch1 got=%b exp=10", channel_hit); end
      drive_frame(16'h0000, 16'h0000);
      idle(2);
   endtask

   task automatic test_saturation();
      drive_frame(16'h8000, 16'h0000);
      checks++; if (channel_hit !== 2'b01) begin failures++; $display("FAIL sat_channel_hit got=%b exp=01", channel_hit); end
      idle(2);
      checks++; if (peak_mag !== 15'h7FFF) begin failures++; $display("FAIL sat_peak got=%h exp=7fff", peak_mag); end
      drive_frame(16'hE000, 16'hFFFF);
      checks++; if (channel_hit !== 2'b01) begin failures++; $display("FAIL neg_channel_hit got=%b exp=01", channel_hit); end
      drive_frame(16'h0000, 16'h0000);
      idle(2);
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL sat_end_state got=%0d exp=0", state); end
   endtask

   task automatic test_all_mode();
      int p0;
      all_mode = 1'b1;
      p0 = pulse_total;
      repeat (5) drive_frame(16'h2000, 16'h0800);
      checks++; if (channel_hit !== 2'b01) begin failures++; $display("FAIL all_channel_hit got=%b exp=01", channel_hit); end
      idle(2);
      checks++; if (pulse_total - p0 !== 0) begin failures++; $display("FAIL all_no_pulse got=%0d exp=0", pulse_total - p0); end
      repeat (3) drive_frame(16'h2000, 16'h2000);
      repeat (12) drive_frame(16'h0000, 16'h0000);
      idle(2);
      checks++; if (pulse_total - p0 !== 1) begin failures++; $display("FAIL all_pulse got=%0d exp=1", pulse_total - p0); end
      checks++; if (clap_count !== 16'd3) begin failures++; $display("FAIL all_count got=%0d exp=3", clap_count); end
      all_mode = 1'b0;
   endtask

   task automatic test_back_to_back();
      int p0, f0;
      do_reset();
      p0 = pulse_total; f0 = frame_no;
      repeat (15) drive_frame(16'h2000, 16'h2000);
      idle(2);
      checks++; if (pulse_total - p0 !== 1) begin failures++; $display("FAIL b2b_lockout got=%0d exp=1", pulse_total - p0); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL b2b_state got=%0d exp=0", state); end
      repeat (3) drive_frame(16'h2000, 16'h2000);
      idle(2);
      checks++; if (pulse_total - p0 !== 2) begin failures++; $display("FAIL b2b_second_pulse got=%0d exp=2", pulse_total - p0); end
      checks++; if (last_pulse_frame - f0 !== 18) begin failures++; $display("FAIL b2b_pulse_frame got=%0d exp=18", last_pulse_frame - f0); end
      checks++; if (clap_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", clap_count); end
      repeat (12) drive_frame(16'h0000, 16'h0000);
      idle(2);
   endtask

   task automatic test_reset_enable();
      int p0;
      repeat (3) drive_frame(16'h2000, 16'h0000);
      drive_frame(16'h0000, 16'h0000);
      idle(2);
      checks++; if (state !== 2'd2) begin failures++; $display("FAIL mid_hold_state got=%0d exp=2", state); end
      reset = 1'b1;
      tick();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL hold_reset_state got=%0d exp=0", state); end
      checks++; if (clap_detected !== 1'b0) begin failures++; $display("FAIL hold_reset_detected got=%b exp=0", clap_detected); end
      checks++; if (clap_count !== 16'd0) begin failures++; $display("FAIL hold_reset_count got=%0d exp=0", clap_count); end
      checks++; if (peak_mag !== 15'd0) begin failures++; $display("FAIL hold_reset_peak got=%h exp=0", peak_mag); end
      reset = 1'b0;
      model_clear();
      m_count = '0; m_peak = '0;
      exp_q.delete(); pipe = 2'b00;
      tick();
      enable = 1'b0;
      model_clear();
      p0 = pulse_total;
      repeat (3) drive_frame(16'h2000, 16'h0000);
      idle(2);
      checks++; if (pulse_total - p0 !== 0) begin failures++; $display("FAIL disabled_pulse got=%0d exp=0", pulse_total - p0); end
      checks++; if (channel_hit !== 2'b01) begin failures++; $display("FAIL disabled_channel_hit got=%b exp=01", channel_hit); end
      checks++; if (peak_mag !== 15'h2000) begin failures++; $display("FAIL disabled_peak got=%h exp=2000", peak_mag); end
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL disabled_state got=%0d exp=0", state); end
      enable = 1'b1;
      repeat (3) drive_frame(16'h2000, 16'h0000);
      idle(2);
      checks++; if (pulse_total - p0 !== 1) begin failures++; $display("FAIL reenabled_pulse got=%0d exp=1", pulse_total - p0); end
      checks++; if (clap_count !== 16'd1) begin failures++; $display("FAIL reenabled_count got=%0d exp=1", clap_count); end
      repeat (12) drive_frame(16'h0000, 16'h0000);
      idle(2);
   endtask

   initial begin
      @(negedge CLOCK_50);
      test_reset();
      test_single_clap();
      test_debounce();
      test_saturation();
      test_all_mode();
      test_back_to_back();
      test_reset_enable();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
